// File: rtl/multicycle_beta_cu_if.sv
// Bundles the signals exchanged between the multi-cycle Beta control unit
// and its datapath/memory side.
//   master : the control unit. It reads the instruction, memory handshakes,
//            the Z flag, IRQ and pc_super. It drives the datapath selects,
//            the load strobes and the state.
//   slave  : the datapath/memory side, with the directions reversed.
interface multicycle_beta_cu_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] instruction;
    logic            imem_ready;
    logic            dmem_ready;
    logic            Z;
    logic            IRQ;
    logic            pc_super;

    logic [5:0]      ALUFN;
    logic            ASEL;
    logic            BSEL;
    logic            RA2SEL;
    logic            WASEL;
    logic            MOE;
    logic            MWR;
    logic [2:0]      PCSEL;
    logic [1:0]      WDSEL;
    logic            WERF;
    logic            IR_LOAD;
    logic            PC_LOAD;
    logic [2:0]      state;

    modport master (
        input  instruction, imem_ready, dmem_ready, Z, IRQ, pc_super,
        output ALUFN, ASEL, BSEL, RA2SEL, WASEL, MOE, MWR, PCSEL, WDSEL,
               WERF, IR_LOAD, PC_LOAD, state
    );

    modport slave (
        output instruction, imem_ready, dmem_ready, Z, IRQ, pc_super,
        input  ALUFN, ASEL, BSEL, RA2SEL, WASEL, MOE, MWR, PCSEL, WDSEL,
               WERF, IR_LOAD, PC_LOAD, state
    );
endinterface

// File: rtl/multicycle_beta_cu.sv
// Multi-cycle control unit for a Beta-style datapath.
// It runs the sequence FETCH/DECODE/EXEC/MEM/WB as a registered FSM. It
// handles variable-latency instruction and data memories, a data-memory
// timeout, and a level interrupt that is sampled only in FETCH.
// Ports:
//   clk   : clock, rising edge.
//   RESET : synchronous, active-high. While it is high, every output is 0.
//   bus   : multicycle_beta_cu_if.master. It carries the instruction, the
//           imem_ready/dmem_ready handshakes, Z, IRQ and pc_super in, and
//           ALUFN/ASEL/BSEL/RA2SEL/WASEL/MOE/MWR/PCSEL/WDSEL/WERF,
//           IR_LOAD, PC_LOAD and state out.
// All outputs are combinational from the state, the captured opcode and the
// live handshake/Z inputs. Don't-care outputs are driven 0.
module multicycle_beta_cu #(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 15,
    parameter bit IRQ_EN      = 1'b1
) (
    input  logic                 clk,
    input  logic                 RESET,
    multicycle_beta_cu_if.master bus
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [2:0] PCSEL_PC4   = 3'b000;
    localparam logic [2:0] PCSEL_BR    = 3'b001;
    localparam logic [2:0] PCSEL_JMP   = 3'b010;
    localparam logic [2:0] PCSEL_ILLOP = 3'b011;
    localparam logic [2:0] PCSEL_XADR  = 3'b100;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_OP, C_OPC, C_LD, C_LDR, C_ST, C_JMP, C_BEQ, C_BNE, C_ILL
    } class_t;

    state_t          state_reg, state_next;
    logic [5:0]      opcode_reg, opcode_next;
    logic [2:0]      cause_reg, cause_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    class_t          cls;

    // Only the opcode field is used. The rest of the word belongs to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.instruction[XLEN-7:0];

    // Instruction class, taken from the captured opcode.
    always_comb begin
        cls = C_ILL;
        if (opcode_reg[5]) begin
            cls = opcode_reg[4] ? C_OPC : C_OP;
        end else begin
            case (opcode_reg)
                6'b011000: cls = C_LD;
                6'b011111: cls = C_LDR;
                6'b011001: cls = C_ST;
                6'b011011: cls = C_JMP;
                6'b011100: cls = C_BEQ;
                6'b011101: cls = C_BNE;
                default:   cls = C_ILL;
            endcase
        end
    end

    // ALU-side selects. They are driven in EXEC and held through MEM so the
    // memory address stays stable while the access is pending.
    logic [5:0] ex_alufn;
    logic       ex_asel, ex_bsel, ex_ra2sel;
    always_comb begin
        ex_alufn  = 6'b000000;
        ex_asel   = 1'b0;
        ex_bsel   = 1'b0;
        ex_ra2sel = 1'b0;
        case (cls)
            C_OP:  ex_alufn = opcode_reg;
            C_OPC: begin ex_alufn = opcode_reg; ex_bsel = 1'b1; end
            C_LD:  begin ex_alufn = 6'b100000;  ex_bsel = 1'b1; end
            C_ST:  begin ex_alufn = 6'b100000;  ex_bsel = 1'b1; ex_ra2sel = 1'b1; end
            C_LDR: begin ex_alufn = 6'b111111;  ex_asel = 1'b1; end
            default: ;
        endcase
    end

    logic       is_mem, is_load;
    assign is_load = (cls == C_LD) || (cls == C_LDR);
    assign is_mem  = is_load || (cls == C_ST);

    // Ungated output values. RESET forces them to 0 where they leave the module.
    logic [5:0] alufn_val;
    logic       asel_val, bsel_val, ra2sel_val, wasel_val, moe_val, mwr_val;
    logic [2:0] pcsel_val;
    logic [1:0] wdsel_val;
    logic       werf_val, ir_load_val, pc_load_val;

    always_comb begin
        state_next  = state_reg;
        opcode_next = opcode_reg;
        cause_next  = cause_reg;
        cnt_next    = cnt_reg;
        alufn_val   = 6'b000000;
        asel_val    = 1'b0;
        bsel_val    = 1'b0;
        ra2sel_val  = 1'b0;
        wasel_val   = 1'b0;
        moe_val     = 1'b0;
        mwr_val     = 1'b0;
        pcsel_val   = PCSEL_PC4;
        wdsel_val   = 2'b00;
        werf_val    = 1'b0;
        ir_load_val = 1'b0;
        pc_load_val = 1'b0;

        case (state_reg)
            FETCH: begin
                if (IRQ_EN && bus.IRQ && !bus.pc_super) begin
                    state_next = TRAP;
                    cause_next = PCSEL_XADR;
                end else begin
                    ir_load_val = bus.imem_ready;
                    if (bus.imem_ready) begin
                        opcode_next = bus.instruction[XLEN-1 -: 6];
                        state_next  = DECODE;
                    end
                end
            end
            DECODE: begin
                if (cls == C_ILL) begin
                    state_next = TRAP;
                    cause_next = PCSEL_ILLOP;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                alufn_val  = ex_alufn;
                asel_val   = ex_asel;
                bsel_val   = ex_bsel;
                ra2sel_val = ex_ra2sel;
                if (is_mem) begin
                    state_next = MEM;
                    cnt_next   = '0;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                alufn_val  = ex_alufn;
                asel_val   = ex_asel;
                bsel_val   = ex_bsel;
                ra2sel_val = ex_ra2sel;
                moe_val    = is_load;
                mwr_val    = !is_load;
                if (bus.dmem_ready) begin
                    // A store completes here. A load still needs WB to write the register.
                    if (is_load) begin
                        state_next = WB;
                    end else begin
                        pc_load_val = 1'b1;
                        state_next  = FETCH;
                    end
                end else if (cnt_reg == CW'(MEM_TIMEOUT - 1)) begin
                    // This is the MEM_TIMEOUT-th unready cycle. Give up. Leaving
                    // MEM drops the strobes from the next cycle on.
                    state_next = TRAP;
                    cause_next = PCSEL_ILLOP;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            WB: begin
                werf_val    = 1'b1;
                pc_load_val = 1'b1;
                state_next  = FETCH;
                case (cls)
                    C_OP, C_OPC: wdsel_val = 2'b01;
                    C_LD, C_LDR: begin wdsel_val = 2'b10; moe_val = 1'b1; end
                    C_JMP:       pcsel_val = PCSEL_JMP;
                    C_BEQ:       pcsel_val = bus.Z ? PCSEL_BR : PCSEL_PC4;
                    C_BNE:       pcsel_val = bus.Z ? PCSEL_PC4 : PCSEL_BR;
                    default: ;
                endcase
            end
            TRAP: begin
                werf_val    = 1'b1;
                wasel_val   = 1'b1;
                pc_load_val = 1'b1;
                pcsel_val   = cause_reg;
                state_next  = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_reg  <= FETCH;
            opcode_reg <= 6'b000000;
            cause_reg  <= 3'b000;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            opcode_reg <= opcode_next;
            cause_reg  <= cause_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign bus.ALUFN   = RESET ? 6'b000000 : alufn_val;
    assign bus.ASEL    = RESET ? 1'b0 : asel_val;
    assign bus.BSEL    = RESET ? 1'b0 : bsel_val;
    assign bus.RA2SEL  = RESET ? 1'b0 : ra2sel_val;
    assign bus.WASEL   = RESET ? 1'b0 : wasel_val;
    assign bus.MOE     = RESET ? 1'b0 : moe_val;
    assign bus.MWR     = RESET ? 1'b0 : mwr_val;
    assign bus.PCSEL   = RESET ? 3'b000 : pcsel_val;
    assign bus.WDSEL   = RESET ? 2'b00 : wdsel_val;
    assign bus.WERF    = RESET ? 1'b0 : werf_val;
    assign bus.IR_LOAD = RESET ? 1'b0 : ir_load_val;
    assign bus.PC_LOAD = RESET ? 1'b0 : pc_load_val;
    assign bus.state   = RESET ? 3'b000 : state_reg;
endmodule

// File: tb/tb_multicycle_beta_cu.sv
// Self-checking bench for multicycle_beta_cu. Each instruction is expanded
// into a timeline of expected per-cycle outputs, using the instruction
// class rules. The timeline is then replayed against the DUT.
module tb_multicycle_beta_cu;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic RESET;
    int   tests = 0;
    int   fails = 0;

    multicycle_beta_cu_if #(.XLEN(32)) bus ();

    multicycle_beta_cu #(.XLEN(32), .MEM_TIMEOUT(TMO), .IRQ_EN(1'b1)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus.master)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic        imem;
        logic        dmem;
        logic        z;
        logic        irq;
        logic [22:0] e;
    } cyc_t;

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;

    function automatic logic rb();
        return 1'($urandom());
    endfunction

    function automatic logic [22:0] mk(logic [2:0] st, logic [5:0] fn, logic a, logic b,
                                       logic r2, logic wa, logic moe, logic mwr,
                                       logic [2:0] pcs, logic [1:0] wd, logic werf,
                                       logic irl, logic pcl);
        return {st, fn, a, b, r2, wa, moe, mwr, pcs, wd, werf, irl, pcl};
    endfunction

    function automatic logic [22:0] obs();
        return {bus.state, bus.ALUFN, bus.ASEL, bus.BSEL, bus.RA2SEL, bus.WASEL,
                bus.MOE, bus.MWR, bus.PCSEL, bus.WDSEL, bus.WERF, bus.IR_LOAD, bus.PC_LOAD};
    endfunction

    // Instruction kinds: 0 OP, 1 OPC, 2 LD, 3 LDR, 4 ST, 5 JMP, 6 BEQ, 7 BNE, 8 illegal
    function automatic int kind_of(logic [5:0] opc);
        if (opc[5:4] == 2'b10) return 0;
        if (opc[5:4] == 2'b11) return 1;
        if (opc == 6'd24) return 2;
        if (opc == 6'd31) return 3;
        if (opc == 6'd25) return 4;
        if (opc == 6'd27) return 5;
        if (opc == 6'd28) return 6;
        if (opc == 6'd29) return 7;
        return 8;
    endfunction

    // Apply one cycle of inputs just after a rising edge, then check at the falling edge.
    task automatic cyc(input string tag, input int idx, input cyc_t c);
        logic [22:0] o;
        bus.imem_ready = c.imem;
        bus.dmem_ready = c.dmem;
        bus.Z          = c.z;
        bus.IRQ        = c.irq;
        @(negedge clk);
        o = obs();
        tests++;
        assert (o === c.e) else begin
            fails++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, o, c.e);
        end
        $display("[TB] %s cycle %0d outputs=%h", tag, idx, o);
        @(posedge clk);
        #1;
    endtask

    // Builds the expected timeline of one instruction, then replays it.
    // dwait = number of unready MEM cycles before dmem_ready (>= TMO never ready).
    task automatic run_txn(input string tag, input logic [5:0] opc, input int iwait,
                           input int dwait, input bit z, input bit irq, input bit sup);
        cyc_t       q[$];
        int         k;
        logic [5:0] fn;
        logic       a, b, r2, ld, st, to_wb;
        logic [2:0] pcs;
        logic [1:0] wd;
        k = kind_of(opc);
        bus.instruction = {opc, 26'($urandom())};
        bus.pc_super    = sup;
        if (irq && !sup) begin
            q.push_back(cyc_t'{rb(), rb(), rb(), 1'b1, mk(S_F, 6'd0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0)});
            q.push_back(cyc_t'{rb(), rb(), rb(), rb(), mk(S_T, 6'd0, 0, 0, 0, 1, 0, 0, 3'b100, 2'd0, 1, 0, 1)});
        end else begin
            for (int i = 0; i < iwait; i++)
                q.push_back(cyc_t'{1'b0, rb(), rb(), irq, mk(S_F, 6'd0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0)});
            q.push_back(cyc_t'{1'b1, rb(), rb(), irq, mk(S_F, 6'd0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 1, 0)});
            q.push_back(cyc_t'{rb(), rb(), rb(), rb(), mk(S_D, 6'd0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0)});
            if (k == 8) begin
                q.push_back(cyc_t'{rb(), rb(), rb(), rb(), mk(S_T, 6'd0, 0, 0, 0, 1, 0, 0, 3'b011, 2'd0, 1, 0, 1)});
            end else begin
                fn = 6'd0; a = 0; b = 0; r2 = 0;
                ld = (k == 2) || (k == 3);
                st = (k == 4);
                if (k == 0) fn = opc;
                if (k == 1) begin fn = opc; b = 1; end
                if (ld || st) begin fn = 6'b100000; b = 1; r2 = st; end
                if (k == 3) begin fn = 6'b111111; a = 1; b = 0; end
                // Z toggled during EXEC must not matter.
                q.push_back(cyc_t'{rb(), rb(), ~z, rb(), mk(S_E, fn, a, b, r2, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0)});
                to_wb = !(ld || st);
                if (ld || st) begin
                    for (int w = 0; w < TMO; w++) begin
                        if (w == dwait) begin
                            q.push_back(cyc_t'{rb(), 1'b1, rb(), rb(),
                                mk(S_M, fn, a, b, r2, 0, ld, st, 3'd0, 2'd0, 0, 0, st)});
                            to_wb = ld;
                            break;
                        end
                        q.push_back(cyc_t'{rb(), 1'b0, rb(), rb(),
                            mk(S_M, fn, a, b, r2, 0, ld, st, 3'd0, 2'd0, 0, 0, 0)});
                        if (w == TMO - 1)
                            q.push_back(cyc_t'{rb(), rb(), rb(), rb(),
                                mk(S_T, 6'd0, 0, 0, 0, 1, 0, 0, 3'b011, 2'd0, 1, 0, 1)});
                    end
                end
                if (to_wb) begin
                    pcs = 3'd0;
                    wd  = 2'd0;
                    if (k <= 1) wd = 2'b01;
                    if (ld) wd = 2'b10;
                    if (k == 5) pcs = 3'b010;
                    if (k == 6) pcs = z ? 3'b001 : 3'b000;
                    if (k == 7) pcs = z ? 3'b000 : 3'b001;
                    q.push_back(cyc_t'{rb(), rb(), z, rb(), mk(S_W, 6'd0, 0, 0, 0, 0, ld, 0, pcs, wd, 1, 0, 1)});
                end
            end
        end
        foreach (q[i]) cyc(tag, i, q[i]);
    endtask

    logic [22:0] zero_v;
    logic [5:0]  ropc;
    logic [5:0]  legal_ops [8];

    initial begin
        zero_v = 23'd0;
        legal_ops = '{6'd24, 6'd31, 6'd25, 6'd27, 6'd28, 6'd29, 6'b100000, 6'b110101};
        RESET = 1'b1;
        bus.instruction = 32'd0;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        bus.Z = 1'b0; bus.IRQ = 1'b0; bus.pc_super = 1'b0;
        @(posedge clk); #1;
        cyc("reset_hold", 0, cyc_t'{1'b1, 1'b1, 1'b0, 1'b1, zero_v});
        cyc("reset_hold", 1, cyc_t'{1'b1, 1'b1, 1'b0, 1'b1, zero_v});
        RESET = 1'b0;
        cyc("reset_idle", 0, cyc_t'{1'b0, 1'b0, 1'b0, 1'b0, zero_v});

        run_txn("add",       6'b100000, 0, 0, 1'b0, 1'b0, 1'b0);
        run_txn("add_iwait", 6'b100101, 2, 0, 1'b1, 1'b0, 1'b0);
        run_txn("ld_wait3",  6'd24, 0, 3, 1'b0, 1'b0, 1'b0);
        run_txn("ldr",       6'd31, 0, 0, 1'b0, 1'b0, 1'b0);
        run_txn("st",        6'd25, 0, 0, 1'b0, 1'b0, 1'b0);
        run_txn("beq_z1",    6'd28, 0, 0, 1'b1, 1'b0, 1'b0);
        run_txn("beq_z0",    6'd28, 0, 0, 1'b0, 1'b0, 1'b0);
        run_txn("bne_z1",    6'd29, 0, 0, 1'b1, 1'b0, 1'b0);
        run_txn("bne_z0",    6'd29, 0, 0, 1'b0, 1'b0, 1'b0);
        run_txn("jmp",       6'd27, 0, 0, 1'b0, 1'b0, 1'b0);
        run_txn("opc",       6'b110000, 0, 0, 1'b0, 1'b0, 1'b0);
        run_txn("illop",     6'b000000, 0, 0, 1'b0, 1'b0, 1'b0);
        run_txn("st_timeout", 6'd25, 0, 100, 1'b0, 1'b0, 1'b0);
        run_txn("ld_last_ok", 6'd24, 0, TMO - 1, 1'b0, 1'b0, 1'b0);
        run_txn("irq_trap",  6'b100000, 0, 0, 1'b0, 1'b1, 1'b0);
        run_txn("irq_super", 6'b100000, 0, 0, 1'b0, 1'b1, 1'b1);

        // Reset asserted during a pending store: MWR drops at once, no PC_LOAD.
        bus.instruction = {6'd25, 26'd0};
        bus.pc_super = 1'b0;
        cyc("rst_mid_st", 0, cyc_t'{1'b1, 1'b0, 1'b0, 1'b0, mk(S_F, 6'd0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 1, 0)});
        cyc("rst_mid_st", 1, cyc_t'{1'b0, 1'b0, 1'b0, 1'b0, mk(S_D, 6'd0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0)});
        cyc("rst_mid_st", 2, cyc_t'{1'b0, 1'b0, 1'b0, 1'b0, mk(S_E, 6'b100000, 0, 1, 1, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0)});
        cyc("rst_mid_st", 3, cyc_t'{1'b0, 1'b0, 1'b0, 1'b0, mk(S_M, 6'b100000, 0, 1, 1, 0, 0, 1, 3'd0, 2'd0, 0, 0, 0)});
        RESET = 1'b1;
        cyc("rst_mid_st", 4, cyc_t'{1'b0, 1'b1, 1'b0, 1'b0, zero_v});
        cyc("rst_mid_st", 5, cyc_t'{1'b0, 1'b1, 1'b0, 1'b0, zero_v});
        RESET = 1'b0;
        cyc("rst_mid_st", 6, cyc_t'{1'b0, 1'b1, 1'b0, 1'b0, zero_v});

        for (int t = 0; t < 60; t++) begin
            int sel, dw;
            sel = int'($urandom_range(0, 9));
            if (sel < 8) ropc = legal_ops[sel];
            else if (sel == 8) ropc = 6'($urandom());
            else ropc = {2'b10, 4'($urandom())};
            if (sel == 6) ropc[3:0] = 4'($urandom());
            dw = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) dw = int'($urandom_range(TMO - 2, TMO + 2));
            run_txn("rand", ropc, int'($urandom_range(0, 2)), dw, rb(),
                    ($urandom_range(0, 3) == 0), rb());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
